// File: rtl/serial_operand_loader_if.sv
// rtl/serial_operand_loader_if.sv - operand/result handshakes and serial adder bit bus (optional SERIAL_LOADER_OVF_EN adds ovf_out)
interface serial_operand_loader_if #(
    parameter int WIDTH = 8
);
    // Operand word handshake
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;

    // Bit-serial adder side
    logic             add_clr;
    logic             bit_valid;
    logic             a_bit;
    logic             b_bit;
    logic             cin_bit;
    logic             s_bit;
    logic             c_bit;

    // Result handshake
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;
`ifdef SERIAL_LOADER_OVF_EN
    logic             ovf_out;
`endif

    // Loader side
    modport slave (
        input  in_valid, a_in, b_in, cin_in, s_bit, c_bit, out_ready,
`ifdef SERIAL_LOADER_OVF_EN
        output ovf_out,
`endif
        output in_ready, add_clr, bit_valid, a_bit, b_bit, cin_bit,
        output out_valid, sum_out, cout_out
    );

    // Producer / consumer / adder side
    modport master (
        output in_valid, a_in, b_in, cin_in, s_bit, c_bit, out_ready,
`ifdef SERIAL_LOADER_OVF_EN
        input  ovf_out,
`endif
        input  in_ready, add_clr, bit_valid, a_bit, b_bit, cin_bit,
        input  out_valid, sum_out, cout_out
    );
endinterface

// File: rtl/serial_operand_loader.sv
// rtl/serial_operand_loader.sv - bit-serial adder operand streamer and sum collector (optional SERIAL_LOADER_OVF_EN adds ovf_out)
module serial_operand_loader #(
    parameter int WIDTH     = 8,
    parameter int ADDER_LAT = 0
) (
    input  logic                   clk,
    input  logic                   clr_n,
    serial_operand_loader_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [2:0]       state_q,     state_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic             cin_q,       cin_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             add_clr_q,   add_clr_d;
    logic             bit_valid_q, bit_valid_d;
    logic             a_bit_q,     a_bit_d;
    logic             b_bit_q,     b_bit_d;
    logic             cin_bit_q,   cin_bit_d;
    logic             bv_dly_q,    bv_dly_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             cout_q,      cout_d;
`ifdef SERIAL_LOADER_OVF_EN
    logic             ovf_q,       ovf_d;
`endif
    logic             cap_en;

    // With a zero-latency adder the sum bit pairs with the bit on the bus;
    // otherwise it arrives one cycle behind the bit that produced it.
    assign cap_en = (ADDER_LAT == 0) ? bit_valid_q : bv_dly_q;

    // Sequencer: accept, clear the adder carry, stream WIDTH bits LSB-first, hold the result
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        cin_d       = cin_q;
        cnt_d       = cnt_q;
        add_clr_d   = 1'b0;
        bit_valid_d = 1'b0;
        a_bit_d     = 1'b0;
        b_bit_d     = 1'b0;
        cin_bit_d   = 1'b0;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                // in_ready is high in IDLE, so in_valid alone completes the handshake
                if (bus.in_valid) begin
                    a_sh_d    = bus.a_in;
                    b_sh_d    = bus.b_in;
                    cin_d     = bus.cin_in;
                    cnt_d     = '0;
                    add_clr_d = 1'b1;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // Present bit 0 on the edge that ends the clear pulse
                bit_valid_d = 1'b1;
                a_bit_d     = a_sh_q[0];
                b_bit_d     = b_sh_q[0];
                cin_bit_d   = cin_q;
                a_sh_d      = a_sh_q >> 1;
                b_sh_d      = b_sh_q >> 1;
                state_d     = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == LAST_BIT) begin
                    if (ADDER_LAT == 0) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d     = ST_CAPTURE;
                    end
                end else begin
                    cnt_d       = cnt_q + CW'(1);
                    bit_valid_d = 1'b1;
                    a_bit_d     = a_sh_q[0];
                    b_bit_d     = b_sh_q[0];
                    a_sh_d      = a_sh_q >> 1;
                    b_sh_d      = b_sh_q >> 1;
                end
            end
            ST_CAPTURE: begin
                // Last delayed sum bit is taken on this edge
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Result assembly: sum bits enter at the MSB so bit k lands at position k after WIDTH captures
    always_comb begin
        sum_d    = sum_q;
        cout_d   = cout_q;
        bv_dly_d = bit_valid_q;
`ifdef SERIAL_LOADER_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (cap_en) begin
            sum_d  = {bus.s_bit, sum_q[WIDTH-1:1]};
            cout_d = bus.c_bit;
`ifdef SERIAL_LOADER_OVF_EN
            // cout_q still holds the carry of the previous bit, so on the
            // final capture this is carry(WIDTH-2) xor carry(WIDTH-1)
            ovf_d  = cout_q ^ bus.c_bit;
`endif
        end
    end

    // Sequencer and adder-bus registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            cin_q       <= 1'b0;
            cnt_q       <= '0;
            add_clr_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            a_bit_q     <= 1'b0;
            b_bit_q     <= 1'b0;
            cin_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            cin_q       <= cin_d;
            cnt_q       <= cnt_d;
            add_clr_q   <= add_clr_d;
            bit_valid_q <= bit_valid_d;
            a_bit_q     <= a_bit_d;
            b_bit_q     <= b_bit_d;
            cin_bit_q   <= cin_bit_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Result registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sum_q    <= '0;
            cout_q   <= 1'b0;
            bv_dly_q <= 1'b0;
`ifdef SERIAL_LOADER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            bv_dly_q <= bv_dly_d;
`ifdef SERIAL_LOADER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.add_clr   = add_clr_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.a_bit     = a_bit_q;
    assign bus.b_bit     = b_bit_q;
    assign bus.cin_bit   = cin_bit_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum_out   = sum_q;
    assign bus.cout_out  = cout_q;
`ifdef SERIAL_LOADER_OVF_EN
    assign bus.ovf_out   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_operand_loader.sv
// tb/tb_serial_operand_loader.sv - randomized self-checking bench for serial_operand_loader (SERIAL_LOADER_OVF_EN optional)
`timescale 1ns/1ps
module tb_serial_operand_loader;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic clr_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_operand_loader_if #(.WIDTH(W)) if0 ();
    serial_operand_loader_if #(.WIDTH(W)) if1 ();

    serial_operand_loader #(.WIDTH(W), .ADDER_LAT(0)) u_dut0 (.clk(clk), .clr_n(clr_n), .bus(if0));
    serial_operand_loader #(.WIDTH(W), .ADDER_LAT(1)) u_dut1 (.clk(clk), .clr_n(clr_n), .bus(if1));

    // Serial adder with registered carry, combinational sum (latency 0)
    logic carry0_q, ci0;
    assign ci0       = carry0_q | if0.cin_bit;
    assign if0.s_bit = if0.a_bit ^ if0.b_bit ^ ci0;
    assign if0.c_bit = (if0.a_bit & if0.b_bit) | (ci0 & (if0.a_bit ^ if0.b_bit));
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n)             carry0_q <= 1'b0;
        else if (if0.add_clr)   carry0_q <= 1'b0;
        else if (if0.bit_valid) carry0_q <= if0.c_bit;
    end

    // Same adder with sum/carry outputs delayed one cycle (latency 1)
    logic carry1_q, ci1, s1_now, c1_now, s1_q, c1_q;
    assign ci1    = carry1_q | if1.cin_bit;
    assign s1_now = if1.a_bit ^ if1.b_bit ^ ci1;
    assign c1_now = (if1.a_bit & if1.b_bit) | (ci1 & (if1.a_bit ^ if1.b_bit));
    assign if1.s_bit = s1_q;
    assign if1.c_bit = c1_q;
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            carry1_q <= 1'b0; s1_q <= 1'b0; c1_q <= 1'b0;
        end else begin
            s1_q <= s1_now;
            c1_q <= c1_now;
            if (if1.add_clr)        carry1_q <= 1'b0;
            else if (if1.bit_valid) carry1_q <= c1_now;
        end
    end

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] r;
        r = ref_add(a, b, c);
        return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    endfunction

    task automatic run_op0(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit noise,
                           output logic [W-1:0] sum, output logic cout, output logic ovf, output int lat,
                           output int nclr, output int nbits, output bit clr_first,
                           output logic [W-1:0] abits, output logic [W-1:0] bbits, output logic [W-1:0] cbits,
                           output bit timeout);
        @(negedge clk);
        if0.in_valid = 1'b1; if0.a_in = a; if0.b_in = b; if0.cin_in = c; if0.out_ready = 1'b0;
        @(posedge clk); #1;
        lat = 1; nclr = 0; nbits = 0; clr_first = 1'b1; timeout = 1'b0;
        abits = '0; bbits = '0; cbits = '0;
        if (!noise) if0.in_valid = 1'b0;
        while (!if0.out_valid && !timeout) begin
            if (if0.add_clr) nclr++;
            if (if0.bit_valid) begin
                if (nclr == 0) clr_first = 1'b0;
                if (nbits < W) begin
                    abits[nbits] = if0.a_bit; bbits[nbits] = if0.b_bit; cbits[nbits] = if0.cin_bit;
                end
                nbits++;
            end
            if (noise) begin
                if0.a_in = W'($urandom); if0.b_in = W'($urandom); if0.cin_in = 1'($urandom);
                if0.out_ready = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
            if (lat > 100) timeout = 1'b1;
        end
        if0.in_valid = 1'b0; if0.out_ready = 1'b0;
        sum = if0.sum_out; cout = if0.cout_out;
`ifdef SERIAL_LOADER_OVF_EN
        ovf = if0.ovf_out;
`else
        ovf = 1'b0;
`endif
    endtask

    task automatic retire0();
        @(negedge clk);
        if0.in_valid = 1'b0; if0.out_ready = 1'b1;
        @(posedge clk); #1;
        if0.out_ready = 1'b0;
    endtask

    task automatic run_op1(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           output logic [W-1:0] sum, output logic cout, output logic ovf,
                           output int lat, output bit timeout);
        @(negedge clk);
        if1.in_valid = 1'b1; if1.a_in = a; if1.b_in = b; if1.cin_in = c; if1.out_ready = 1'b0;
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        lat = 1; timeout = 1'b0;
        while (!if1.out_valid && !timeout) begin
            @(posedge clk); #1;
            lat++;
            if (lat > 100) timeout = 1'b1;
        end
        sum = if1.sum_out; cout = if1.cout_out;
`ifdef SERIAL_LOADER_OVF_EN
        ovf = if1.ovf_out;
`else
        ovf = 1'b0;
`endif
        @(negedge clk); if1.out_ready = 1'b1;
        @(posedge clk); #1; if1.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 clr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({if0.add_clr, if0.bit_valid, if0.a_bit, if0.b_bit, if0.cin_bit, if0.out_valid, if0.cout_out} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl0 got=%b exp=0000000",
                {if0.add_clr, if0.bit_valid, if0.a_bit, if0.b_bit, if0.cin_bit, if0.out_valid, if0.cout_out});
        end
        checks++;
        if (if0.sum_out !== '0 || if0.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_data0 sum=%h in_ready=%b exp sum=00 in_ready=1", if0.sum_out, if0.in_ready);
        end
        checks++;
        if ({if1.add_clr, if1.bit_valid, if1.out_valid, if1.cout_out, if1.in_ready} !== 5'b00001 || if1.sum_out !== '0) begin
            failures++; $display("FAIL reset_dut1 ctrl=%b sum=%h exp ctrl=00001 sum=00",
                {if1.add_clr, if1.bit_valid, if1.out_valid, if1.cout_out, if1.in_ready}, if1.sum_out);
        end
`ifdef SERIAL_LOADER_OVF_EN
        checks++;
        if (if0.ovf_out !== 1'b0) begin
            failures++; $display("FAIL reset_ovf got=%b exp=0", if0.ovf_out);
        end
`endif
        @(negedge clk) clr_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic         vc [4];
        logic [W-1:0] sum, ab, bb, cb;
        logic         cout, ovf;
        logic [W:0]   e;
        int           lat, nclr, nbits;
        bit           cf, to;
        va = '{8'h5A, 8'hFF, 8'h00, 8'h7F};
        vb = '{8'h33, 8'h01, 8'h00, 8'h01};
        vc = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            e = ref_add(va[i], vb[i], vc[i]);
            run_op0(va[i], vb[i], vc[i], 1'b0, sum, cout, ovf, lat, nclr, nbits, cf, ab, bb, cb, to);
            checks++;
            if (to) begin failures++; $display("FAIL dir_timeout op=%0d out_valid never rose", i); end
            checks++;
            if ({cout, sum} !== e) begin failures++; $display("FAIL dir_result op=%0d got=%h exp=%h", i, {cout, sum}, e); end
            checks++;
            if (lat !== W + 2) begin failures++; $display("FAIL dir_latency op=%0d got=%0d exp=%0d", i, lat, W + 2); end
            checks++;
            if (nclr !== 1 || cf !== 1'b1) begin
                failures++; $display("FAIL dir_add_clr op=%0d pulses=%0d before_bits=%0d exp 1/1", i, nclr, cf);
            end
            checks++;
            if (nbits !== W || ab !== va[i] || bb !== vb[i]) begin
                failures++; $display("FAIL dir_bits op=%0d n=%0d a=%h b=%h exp n=%0d a=%h b=%h", i, nbits, ab, bb, W, va[i], vb[i]);
            end
            checks++;
            if (cb !== {{(W-1){1'b0}}, vc[i]}) begin
                failures++; $display("FAIL dir_cin_bit op=%0d got=%b exp=%b", i, cb, {{(W-1){1'b0}}, vc[i]});
            end
`ifdef SERIAL_LOADER_OVF_EN
            checks++;
            if (ovf !== ref_ovf(va[i], vb[i], vc[i])) begin
                failures++; $display("FAIL dir_ovf op=%0d got=%b exp=%b", i, ovf, ref_ovf(va[i], vb[i], vc[i]));
            end
`endif
            retire0();
            checks++;
            if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin
                failures++; $display("FAIL dir_retire op=%0d in_ready=%b out_valid=%b exp 1/0", i, if0.in_ready, if0.out_valid);
            end
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] a, b, ja, jb, sum, ab, bb, cb;
        logic         c, jc, cout, ovf;
        logic [W:0]   e, je;
        int           lat, nclr, nbits, n;
        bit           cf, to;
        a = W'($urandom); b = W'($urandom); c = 1'($urandom);
        ja = W'($urandom); jb = W'($urandom); jc = 1'($urandom);
        e = ref_add(a, b, c); je = ref_add(ja, jb, jc);
        run_op0(a, b, c, 1'b0, sum, cout, ovf, lat, nclr, nbits, cf, ab, bb, cb, to);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if0.in_valid = 1'b1; if0.a_in = ja; if0.b_in = jb; if0.cin_in = jc; if0.out_ready = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (if0.out_valid !== 1'b1 || {if0.cout_out, if0.sum_out} !== e || if0.in_ready !== 1'b0 || if0.add_clr !== 1'b0) begin
                failures++; $display("FAIL hold_stable cyc=%0d ov=%b res=%h rdy=%b clr=%b exp ov=1 res=%h rdy=0 clr=0",
                    i, if0.out_valid, {if0.cout_out, if0.sum_out}, if0.in_ready, if0.add_clr, e);
            end
        end
        @(negedge clk) if0.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1 || if0.add_clr !== 1'b0) begin
            failures++; $display("FAIL hold_release ov=%b rdy=%b clr=%b exp 0/1/0", if0.out_valid, if0.in_ready, if0.add_clr);
        end
        @(negedge clk) if0.out_ready = 1'b0;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        checks++;
        if (if0.add_clr !== 1'b1 || if0.in_ready !== 1'b0) begin
            failures++; $display("FAIL hold_next_accept clr=%b rdy=%b exp 1/0", if0.add_clr, if0.in_ready);
        end
        n = 0;
        while (!if0.out_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if ({if0.cout_out, if0.sum_out} !== je || n >= 100) begin
            failures++; $display("FAIL hold_next_result got=%h exp=%h waited=%0d", {if0.cout_out, if0.sum_out}, je, n);
        end
        retire0();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] sum, ab, bb, cb;
        logic         cout, ovf;
        int           lat, nclr, nbits, n, k;
        bit           cf, to;
        @(negedge clk);
        if0.in_valid = 1'b1; if0.a_in = W'($urandom); if0.b_in = W'($urandom); if0.cin_in = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        n = 0; k = 0;
        while (k < 4 && n < 100) begin
            if (if0.bit_valid) k++;
            if (k < 4) begin @(posedge clk); #1; end
            n++;
        end
        checks++;
        if (k !== 4) begin failures++; $display("FAIL midrst_reach_bit3 bits=%0d exp=4", k); end
        #2 clr_n = 1'b0;
        #1;
        checks++;
        if ({if0.add_clr, if0.bit_valid, if0.a_bit, if0.b_bit, if0.cin_bit, if0.out_valid, if0.cout_out} !== 7'b0 ||
            if0.sum_out !== '0 || if0.in_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_async ctrl=%b sum=%h rdy=%b exp ctrl=0 sum=0 rdy=1",
                {if0.add_clr, if0.bit_valid, if0.a_bit, if0.b_bit, if0.cin_bit, if0.out_valid, if0.cout_out}, if0.sum_out, if0.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (if0.add_clr !== 1'b0 || if0.bit_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_held clr=%b bv=%b exp 0/0", if0.add_clr, if0.bit_valid);
        end
        @(negedge clk) clr_n = 1'b1;
        run_op0(8'h10, 8'h20, 1'b0, 1'b0, sum, cout, ovf, lat, nclr, nbits, cf, ab, bb, cb, to);
        checks++;
        if ({cout, sum} !== ref_add(8'h10, 8'h20, 1'b0) || lat !== W + 2 || nclr !== 1 || to) begin
            failures++; $display("FAIL midrst_next res=%h lat=%0d clr=%0d exp res=%h lat=%0d clr=1",
                {cout, sum}, lat, nclr, ref_add(8'h10, 8'h20, 1'b0), W + 2);
        end
        retire0();
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, sum, ab, bb, cb;
        logic         c, cout, ovf;
        logic [W:0]   e;
        int           lat, nclr, nbits;
        bit           cf, to;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            e = ref_add(a, b, c);
            run_op0(a, b, c, 1'b1, sum, cout, ovf, lat, nclr, nbits, cf, ab, bb, cb, to);
            checks++;
            if ({cout, sum} !== e || to) begin
                failures++; $display("FAIL rand_result it=%0d a=%h b=%h c=%b got=%h exp=%h", i, a, b, c, {cout, sum}, e);
            end
            checks++;
            if (lat !== W + 2 || nclr !== 1 || ab !== a || bb !== b) begin
                failures++; $display("FAIL rand_stream it=%0d lat=%0d clr=%0d a=%h b=%h exp lat=%0d clr=1 a=%h b=%h",
                    i, lat, nclr, ab, bb, W + 2, a, b);
            end
`ifdef SERIAL_LOADER_OVF_EN
            checks++;
            if (ovf !== ref_ovf(a, b, c)) begin
                failures++; $display("FAIL rand_ovf it=%0d got=%b exp=%b", i, ovf, ref_ovf(a, b, c));
            end
`endif
            repeat ($urandom_range(0, 3)) @(posedge clk);
            retire0();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   e;
        int           last, npulse, n;
        a = W'($urandom); b = W'($urandom); c = 1'($urandom);
        e = ref_add(a, b, c);
        last = -1; npulse = 0;
        @(negedge clk);
        if0.in_valid = 1'b1; if0.a_in = a; if0.b_in = b; if0.cin_in = c; if0.out_ready = 1'b1;
        for (int i = 0; i < 4 * (W + 3); i++) begin
            @(posedge clk); #1;
            if (if0.add_clr) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last !== W + 3) begin
                        failures++; $display("FAIL b2b_period got=%0d exp=%0d", i - last, W + 3);
                    end
                end
                last = i; npulse++;
            end
            if (if0.out_valid) begin
                checks++;
                if ({if0.cout_out, if0.sum_out} !== e) begin
                    failures++; $display("FAIL b2b_result got=%h exp=%h", {if0.cout_out, if0.sum_out}, e);
                end
            end
        end
        checks++;
        if (npulse < 3) begin failures++; $display("FAIL b2b_count got=%0d exp>=3", npulse); end
        @(negedge clk) if0.in_valid = 1'b0;
        n = 0;
        while (!if0.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if0.out_ready = 1'b0;
        checks++;
        if (if0.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_drain in_ready=%b exp=1", if0.in_ready); end
    endtask

    task automatic test_lat1();
        logic [W-1:0] a, b, sum;
        logic         c, cout, ovf;
        logic [W:0]   e;
        int           lat;
        bit           to;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin a = 8'hAA; b = 8'h55; c = 1'b1; end
            else begin a = W'($urandom); b = W'($urandom); c = 1'($urandom); end
            e = ref_add(a, b, c);
            run_op1(a, b, c, sum, cout, ovf, lat, to);
            checks++;
            if ({cout, sum} !== e || to) begin
                failures++; $display("FAIL lat1_result it=%0d a=%h b=%h c=%b got=%h exp=%h", i, a, b, c, {cout, sum}, e);
            end
            checks++;
            if (lat !== W + 3) begin failures++; $display("FAIL lat1_latency it=%0d got=%0d exp=%0d", i, lat, W + 3); end
`ifdef SERIAL_LOADER_OVF_EN
            checks++;
            if (ovf !== ref_ovf(a, b, c)) begin
                failures++; $display("FAIL lat1_ovf it=%0d got=%b exp=%b", i, ovf, ref_ovf(a, b, c));
            end
`endif
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.in_valid = 1'b0; if0.a_in = '0; if0.b_in = '0; if0.cin_in = 1'b0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.a_in = '0; if1.b_in = '0; if1.cin_in = 1'b0; if1.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_lat1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
